// File: rtl/hazard_unit.sv
// Pipeline hazard controller: RAW forwarding, load-use bubbles, branch flushes,
// memory-wait freeze, stall-cycle counter and sticky memory-timeout flag.
module hazard_unit #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic [1:0]       ResultSrc_E,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             BranchTaken_E,
  input  logic             MemReq_M,
  input  logic             MemReady,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [CNT_W-1:0] StallCnt,
  output logic             MemTimeout
);

  localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(MAX_WAIT);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               memstall;
  logic               load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == rs))      return 2'b10;
    else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == rs)) return 2'b01;
    else                                                   return 2'b00;
  endfunction

  assign ForwardA_E = fwd_sel(Rs1_E);
  assign ForwardB_E = fwd_sel(Rs2_E);

  assign memstall = MemReq_M && !MemReady;
  assign load_use = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                    ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  // Memory freeze masks branch/load-use; those conditions persist upstream.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (memstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (BranchTaken_E) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wcnt_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (memstall) state_d = ST_WAIT;
      ST_WAIT: if (MemReady || !MemReq_M) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    wcnt_d      = '0;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) begin
      wcnt_d = (wcnt_q == WAIT_MAX) ? wcnt_q : wcnt_q + WCNT_W'(1);
      if (wcnt_q >= WAIT_LAST) timeout_d = 1'b1;
    end
    if (StallF && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign StallCnt   = stall_cnt_q;
  assign MemTimeout = timeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed + random bench for hazard_unit against a rule-level reference model.
module tb_hazard_unit;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic [1:0] ResultSrc_E;
  logic RegWrite_M, RegWrite_W, BranchTaken_E, MemReq_M, MemReady;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [CNT_W-1:0] StallCnt;

  int n_assert = 0;
  int n_fail = 0;

  // reference model state
  bit m_wait;
  int m_wcnt;
  bit m_to;
  int m_scnt;
  int cnt_before;

  hazard_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W), .ResultSrc_E(ResultSrc_E),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .BranchTaken_E(BranchTaken_E), .MemReq_M(MemReq_M), .MemReady(MemReady),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .StallCnt(StallCnt), .MemTimeout(MemTimeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_fwd(input logic [4:0] rs);
    if (RegWrite_M && Rd_M != 0 && Rd_M == rs) return 2;
    if (RegWrite_W && Rd_W != 0 && Rd_W == rs) return 1;
    return 0;
  endfunction

  // Expected stall/flush vector {F,D,E,M,FD,FE,FW}
  function automatic logic [6:0] ref_ctl();
    bit ms, lu;
    ms = MemReq_M && !MemReady;
    lu = (ResultSrc_E == 2'b01) && (Rd_E != 0) && (Rd_E == Rs1_D || Rd_E == Rs2_D);
    if (ms) return 7'b1111_001;
    if (BranchTaken_E) return 7'b0000_110;
    if (lu) return 7'b1100_010;
    return 7'b0;
  endfunction

  task automatic check_all();
    chk("fwdA", 32'(ForwardA_E), 32'(ref_fwd(Rs1_E)));
    chk("fwdB", 32'(ForwardB_E), 32'(ref_fwd(Rs2_E)));
    chk("ctl", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 32'(ref_ctl()));
    chk("stallcnt", 32'(StallCnt), 32'(m_scnt));
    chk("timeout", 32'(MemTimeout), 32'(m_to));
  endtask

  task automatic model_edge();
    bit ms;
    logic [6:0] c;
    ms = MemReq_M && !MemReady;
    c = ref_ctl();
    if (c[6] && m_scnt < CNT_MAX) m_scnt++;
    if (!m_wait) begin
      if (ms) begin m_wait = 1; m_wcnt = 0; end
    end else if (ms) begin
      m_wcnt++;
      if (m_wcnt >= MAX_WAIT) m_to = 1;
    end else begin
      m_wait = 0; m_wcnt = 0;
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_wcnt = 0; m_to = 0; m_scnt = 0;
  endtask

  task automatic clear_inputs();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; Rd_M = 0; Rd_W = 0;
    ResultSrc_E = 0; RegWrite_M = 0; RegWrite_W = 0; BranchTaken_E = 0;
    MemReq_M = 0; MemReady = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied away from the clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_stallcnt", 32'(StallCnt), 32'd0);
    chk("rst_timeout", 32'(MemTimeout), 32'd0);
    clear_inputs();
    #1;
    chk("rst_outs", 32'({ForwardA_E, ForwardB_E, StallF, StallD, StallE, StallM,
                        FlushD, FlushE, FlushW}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    clear_inputs();
    @(posedge clk);
    #1;
    chk("init_stallcnt", 32'(StallCnt), 32'd0);
    chk("init_timeout", 32'(MemTimeout), 32'd0);
    chk("init_ctl", 32'({StallF, FlushD, FlushE, FlushW, ForwardA_E}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Forwarding priority and x0
    Rd_M = 5; RegWrite_M = 1; Rs1_E = 5; Rd_W = 5; RegWrite_W = 1;
    cycle();
    chk("fwd_mem", 32'(ForwardA_E), 32'b10);
    RegWrite_M = 0;
    cycle();
    chk("fwd_wb", 32'(ForwardA_E), 32'b01);
    Rs1_E = 0; Rd_M = 0; RegWrite_M = 1;
    cycle();
    chk("fwd_x0", 32'(ForwardA_E), 32'b00);
    clear_inputs();

    // Load-use bubble: one cycle, then the load moves on
    cnt_before = m_scnt;
    Rd_E = 7; ResultSrc_E = 2'b01; Rs2_D = 7;
    cycle();
    ResultSrc_E = 0; Rd_E = 0;
    cycle();
    chk("lu_cnt", 32'(StallCnt), 32'(cnt_before + 1));
    ResultSrc_E = 2'b01; Rd_E = 0; Rs2_D = 0;
    #1;
    chk("lu_x0", 32'({StallF, StallD, FlushE}), 32'd0);
    cycle();

    // Branch overrides load-use
    Rd_E = 7; ResultSrc_E = 2'b01; Rs2_D = 7; BranchTaken_E = 1;
    #1;
    chk("br_lu", 32'({StallF, StallD, FlushD, FlushE}), 32'b0011);
    cycle();
    clear_inputs();

    // Memory stall with pending branch
    do_reset();
    MemReq_M = 1; MemReady = 0; BranchTaken_E = 1;
    repeat (3) cycle();
    MemReady = 1;
    #1;
    chk("ms_release", 32'({StallF, FlushD, FlushE, FlushW}), 32'b0110);
    cycle();
    clear_inputs();
    cycle();
    chk("ms_cnt", 32'(StallCnt), 32'd3);
    MemReq_M = 1; MemReady = 1;
    cycle();
    clear_inputs();

    // Timeout and stickiness
    do_reset();
    MemReq_M = 1; MemReady = 0;
    repeat (6) cycle();
    chk("to_set", 32'(MemTimeout), 32'd1);
    clear_inputs();
    repeat (3) cycle();
    chk("to_sticky", 32'(MemTimeout), 32'd1);

    // Reset mid-wait
    MemReq_M = 1; MemReady = 0;
    repeat (3) cycle();
    do_reset();
    MemReq_M = 1; MemReady = 0;
    repeat (4) cycle();
    chk("to_after_rst", 32'(MemTimeout), 32'd0);
    clear_inputs();
    cycle();

    // StallCnt saturation
    do_reset();
    Rd_E = 3; ResultSrc_E = 2'b01; Rs1_D = 3;
    repeat (20) cycle();
    chk("sat", 32'(StallCnt), 32'(CNT_MAX));
    clear_inputs();

    // Random phase
    do_reset();
    for (int i = 0; i < 400; i++) begin
      Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
      Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
      Rd_E = 5'($urandom_range(0, 3)); Rd_M = 5'($urandom_range(0, 3));
      Rd_W = 5'($urandom_range(0, 3));
      ResultSrc_E = 2'($urandom_range(0, 3));
      RegWrite_M = 1'($urandom_range(0, 1)); RegWrite_W = 1'($urandom_range(0, 1));
      BranchTaken_E = ($urandom_range(0, 3) == 0);
      MemReq_M = ($urandom_range(0, 2) == 0);
      MemReady = ($urandom_range(0, 1) == 0);
      if (i == 200) do_reset();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
